// File: rtl/mpmc11_to_wdog_if.sv
//------------------------------------------------------------------------------
// mpmc11_to_wdog_if : controller state type and the watchdog's bus interface.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mpmc11_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACT  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    PRE  = 3'd4,
    REF  = 3'd5,
    PDN  = 3'd6,
    SRF  = 3'd7
  } mpmc11_state_t;
endpackage

interface mpmc11_to_wdog_if #(
  parameter int CNT_WID = 16,
  parameter int EVT_WID = 8
);
  import mpmc11_pkg::*;

  mpmc11_state_t        state;
  mpmc11_state_t        prev_state;
  logic [CNT_WID-1:0]   limit;
  logic                 clr;
  logic [CNT_WID-1:0]   to_cnt;
  logic                 to_tick;
  logic                 to_flag;
  logic [EVT_WID-1:0]   to_evt_cnt;
  mpmc11_state_t        to_state;

  // Controller / CSR side
  modport master (
    output state, prev_state, limit, clr,
    input  to_cnt, to_tick, to_flag, to_evt_cnt, to_state
  );

  // Watchdog side
  modport slave (
    input  state, prev_state, limit, clr,
    output to_cnt, to_tick, to_flag, to_evt_cnt, to_state
  );
endinterface

`default_nettype wire

// File: rtl/mpmc11_to_wdog.sv
//------------------------------------------------------------------------------
// mpmc11_to_wdog : dwell-time watchdog for the mpmc11 controller state machine.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mpmc11_to_wdog
  import mpmc11_pkg::*;
#(
  parameter int CNT_WID  = 16,
  parameter int TO_LIMIT = 512,
  parameter int MODE     = 0,
  parameter int EVT_WID  = 8
) (
  input  logic            clk,
  input  logic            rst,
  mpmc11_to_wdog_if.slave bus
);

  localparam logic [CNT_WID-1:0] DEF_LIMIT = CNT_WID'(TO_LIMIT);
  localparam logic [EVT_WID-1:0] EVT_MAX   = '1;
  localparam logic               HOLD_MODE = (MODE == 1);

  logic [CNT_WID-1:0] eff_limit;
  logic               dwell_break;
  logic               timeout;

  logic [CNT_WID-1:0] to_cnt_q,     to_cnt_d;
  logic               to_tick_q,    to_tick_d;
  logic               to_flag_q,    to_flag_d;
  logic [EVT_WID-1:0] to_evt_cnt_q, to_evt_cnt_d;
  mpmc11_state_t      to_state_q,   to_state_d;
  logic               fired_q,      fired_d;

  always_comb begin
    eff_limit    = (bus.limit == '0) ? DEF_LIMIT : bus.limit;
    dwell_break  = (bus.state == IDLE) || (bus.state != bus.prev_state);
    timeout      = !dwell_break && (to_cnt_q >= eff_limit) && !fired_q;

    to_cnt_d     = to_cnt_q;
    to_tick_d    = 1'b0;
    to_flag_d    = to_flag_q;
    to_evt_cnt_d = to_evt_cnt_q;
    to_state_d   = to_state_q;
    fired_d      = fired_q;

    if (bus.clr) begin
      to_flag_d    = 1'b0;
      to_evt_cnt_d = '0;
    end

    if (dwell_break) begin
      to_cnt_d = '0;
      fired_d  = 1'b0;
    end else if (timeout) begin
      to_tick_d  = 1'b1;
      to_state_d = bus.state;
      to_flag_d  = 1'b1;
      // A coincident clear wipes the history but keeps this event.
      if (bus.clr) begin
        to_evt_cnt_d = EVT_WID'(1);
      end else if (to_evt_cnt_q != EVT_MAX) begin
        to_evt_cnt_d = to_evt_cnt_q + EVT_WID'(1);
      end
      if (HOLD_MODE) begin
        fired_d = 1'b1;
      end else begin
        to_cnt_d = '0;
      end
    end else if (!(HOLD_MODE && fired_q)) begin
      to_cnt_d = to_cnt_q + CNT_WID'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q     <= '0;
      to_tick_q    <= 1'b0;
      to_flag_q    <= 1'b0;
      to_evt_cnt_q <= '0;
      to_state_q   <= IDLE;
      fired_q      <= 1'b0;
    end else begin
      to_cnt_q     <= to_cnt_d;
      to_tick_q    <= to_tick_d;
      to_flag_q    <= to_flag_d;
      to_evt_cnt_q <= to_evt_cnt_d;
      to_state_q   <= to_state_d;
      fired_q      <= fired_d;
    end
  end

  assign bus.to_cnt     = to_cnt_q;
  assign bus.to_tick    = to_tick_q;
  assign bus.to_flag    = to_flag_q;
  assign bus.to_evt_cnt = to_evt_cnt_q;
  assign bus.to_state   = to_state_q;

endmodule

`default_nettype wire

// File: tb/tb_mpmc11_to_wdog.sv
//------------------------------------------------------------------------------
// tb_mpmc11_to_wdog : restart, hold and narrow-counter watchdogs on shared stimulus.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mpmc11_to_wdog;
  import mpmc11_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  mpmc11_state_t st  = IDLE;
  mpmc11_state_t pst = IDLE;
  logic [15:0]   lim = '0;
  logic          clr = 1'b0;

  always #5 clk = ~clk;

  mpmc11_to_wdog_if #(.CNT_WID(16), .EVT_WID(8)) if0 ();
  mpmc11_to_wdog_if #(.CNT_WID(16), .EVT_WID(8)) if1 ();
  mpmc11_to_wdog_if #(.CNT_WID(16), .EVT_WID(2)) if2 ();

  assign if0.state = st;  assign if0.prev_state = pst;  assign if0.limit = lim;  assign if0.clr = clr;
  assign if1.state = st;  assign if1.prev_state = pst;  assign if1.limit = lim;  assign if1.clr = clr;
  assign if2.state = st;  assign if2.prev_state = pst;  assign if2.limit = lim;  assign if2.clr = clr;

  mpmc11_to_wdog #(.CNT_WID(16), .TO_LIMIT(512), .MODE(0), .EVT_WID(8)) u0 (.clk(clk), .rst(rst), .bus(if0));
  mpmc11_to_wdog #(.CNT_WID(16), .TO_LIMIT(512), .MODE(1), .EVT_WID(8)) u1 (.clk(clk), .rst(rst), .bus(if1));
  mpmc11_to_wdog #(.CNT_WID(16), .TO_LIMIT(512), .MODE(0), .EVT_WID(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

  // Reference model: one record per watchdog, advanced from the rules once per edge.
  int m_cnt[3], m_tick[3], m_flag[3], m_evt[3], m_st[3], m_fired[3];
  int m_hold[3] = '{0, 1, 0};
  int m_emax[3] = '{255, 255, 3};

  int checks = 0;
  int fails  = 0;

  task automatic check(input string nm, input int k, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      fails++;
      $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", nm, k, $time, act, exp);
    end
  endtask

  task automatic get(input int k, output logic [31:0] c, output logic [31:0] t,
                     output logic [31:0] f, output logic [31:0] e, output logic [31:0] s);
    case (k)
      0:       begin c = 32'(if0.to_cnt); t = 32'(if0.to_tick); f = 32'(if0.to_flag);
                     e = 32'(if0.to_evt_cnt); s = 32'(if0.to_state); end
      1:       begin c = 32'(if1.to_cnt); t = 32'(if1.to_tick); f = 32'(if1.to_flag);
                     e = 32'(if1.to_evt_cnt); s = 32'(if1.to_state); end
      default: begin c = 32'(if2.to_cnt); t = 32'(if2.to_tick); f = 32'(if2.to_flag);
                     e = 32'(if2.to_evt_cnt); s = 32'(if2.to_state); end
    endcase
  endtask

  task automatic model_step();
    int  eff;
    bit  fire;
    eff = (lim == 0) ? 512 : int'(lim);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_cnt[k] = 0; m_tick[k] = 0; m_flag[k] = 0; m_evt[k] = 0; m_st[k] = 0; m_fired[k] = 0;
      end else begin
        fire = 0;
        m_tick[k] = 0;
        if (st == IDLE || st != pst) begin
          m_cnt[k] = 0; m_fired[k] = 0;
        end else if (m_cnt[k] >= eff && m_fired[k] == 0) begin
          fire = 1;
          m_tick[k] = 1;
          m_st[k] = int'(st);
          if (m_hold[k] != 0) m_fired[k] = 1;
          else                m_cnt[k] = 0;
        end else if (!(m_hold[k] != 0 && m_fired[k] != 0)) begin
          m_cnt[k] = m_cnt[k] + 1;
        end
        if (fire) begin
          m_flag[k] = 1;
          m_evt[k]  = clr ? 1 : ((m_evt[k] < m_emax[k]) ? m_evt[k] + 1 : m_emax[k]);
        end else if (clr) begin
          m_flag[k] = 0; m_evt[k] = 0;
        end
      end
    end
  endtask

  task automatic cyc();
    logic [31:0] c, t, f, e, s;
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 3; k++) begin
      get(k, c, t, f, e, s);
      check("cnt",   k, c, m_cnt[k]);
      check("tick",  k, t, m_tick[k]);
      check("flag",  k, f, m_flag[k]);
      check("evt",   k, e, m_evt[k]);
      check("state", k, s, m_st[k]);
    end
  endtask

  task automatic step(input mpmc11_state_t s);
    pst = st;
    st  = s;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0;
    step(IDLE);
    step(IDLE);
    rst = 1'b0;
  endtask

  typedef struct {
    mpmc11_state_t s;
    mpmc11_state_t p;
    int            lim;
    logic          clr;
    int            cnt;
    int            tick;
    int            flag;
    int            evt;
    mpmc11_state_t ts;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int nt, last, gap;
    logic [31:0] c, t, f, e, s;

    // Hand-derived dwell in hold mode with limit 3 (checked on the hold-mode watchdog).
    tbl[0]  = '{ACT,  IDLE, 3, 1'b0, 0, 0, 0, 0, IDLE};
    tbl[1]  = '{ACT,  ACT,  3, 1'b0, 1, 0, 0, 0, IDLE};
    tbl[2]  = '{ACT,  ACT,  3, 1'b0, 2, 0, 0, 0, IDLE};
    tbl[3]  = '{ACT,  ACT,  3, 1'b0, 3, 0, 0, 0, IDLE};
    tbl[4]  = '{ACT,  ACT,  3, 1'b0, 3, 1, 1, 1, ACT};
    tbl[5]  = '{ACT,  ACT,  3, 1'b0, 3, 0, 1, 1, ACT};
    tbl[6]  = '{ACT,  ACT,  1, 1'b0, 3, 0, 1, 1, ACT};
    tbl[7]  = '{RD,   ACT,  3, 1'b0, 0, 0, 1, 1, ACT};
    tbl[8]  = '{RD,   RD,   3, 1'b1, 1, 0, 0, 0, ACT};
    tbl[9]  = '{RD,   RD,   3, 1'b0, 2, 0, 0, 0, ACT};
    tbl[10] = '{RD,   RD,   3, 1'b0, 3, 0, 0, 0, ACT};
    tbl[11] = '{RD,   RD,   3, 1'b1, 3, 1, 1, 1, RD};
    tbl[12] = '{IDLE, RD,   3, 1'b0, 0, 0, 1, 1, RD};
    tbl[13] = '{IDLE, IDLE, 3, 1'b0, 0, 0, 1, 1, RD};

    do_reset();
    for (int k = 0; k < 3; k++) begin
      get(k, c, t, f, e, s);
      check("rst_cnt", k, c, 0);
      check("rst_state", k, s, 0);
    end

    // Restart mode, default limit: two ticks 513 edges apart.
    lim = '0;
    step(ACT);
    nt = 0; last = -1; gap = 0;
    for (int i = 0; i < 1100; i++) begin
      step(ACT);
      if (if0.to_tick === 1'b1) begin
        nt++;
        if (last >= 0) gap = i - last;
        last = i;
      end
    end
    check("m0_ticks", 0, 32'(nt), 2);
    check("m0_gap",   0, 32'(gap), 513);
    check("m0_evt",   0, 32'(if0.to_evt_cnt), 2);
    check("m0_flag",  0, 32'(if0.to_flag), 1);
    check("m0_state", 0, 32'(if0.to_state), int'(ACT));
    check("m1_frozen", 1, 32'(if1.to_cnt), 512);

    // Hold mode, limit 10: single tick, re-arm after a state change.
    do_reset();
    lim = 16'd10;
    step(ACT);
    nt = 0;
    for (int i = 0; i < 40; i++) begin
      step(ACT);
      if (if1.to_tick === 1'b1) nt++;
    end
    check("m1_ticks", 1, 32'(nt), 1);
    check("m1_cnt",   1, 32'(if1.to_cnt), 10);
    step(RD);
    step(ACT);
    for (int i = 0; i < 15; i++) step(ACT);
    check("m1_evt", 1, 32'(if1.to_evt_cnt), 2);

    // Long IDLE stretch never times out.
    do_reset();
    lim = '0;
    nt = 0;
    for (int i = 0; i < 5000; i++) begin
      step(IDLE);
      if (if0.to_tick === 1'b1 || if1.to_tick === 1'b1) nt++;
    end
    check("idle_ticks", 0, 32'(nt), 0);
    check("idle_cnt",   0, 32'(if0.to_cnt), 0);

    // State change one cycle short of the limit.
    lim = 16'd10;
    step(ACT);
    for (int i = 0; i < 9; i++) step(ACT);
    check("pre_chg_cnt", 1, 32'(if1.to_cnt), 9);
    step(RD);
    check("chg_cnt",  1, 32'(if1.to_cnt), 0);
    check("chg_tick", 1, 32'(if1.to_tick), 0);

    // Clear colliding with a timeout, then clear alone, then saturation.
    do_reset();
    lim = 16'd2;
    step(ACT);
    for (int i = 0; i < 15; i++) step(ACT);
    check("evt5", 0, 32'(if0.to_evt_cnt), 5);
    step(ACT);
    step(ACT);
    clr = 1'b1;
    step(ACT);
    check("coll_evt",  0, 32'(if0.to_evt_cnt), 1);
    check("coll_flag", 0, 32'(if0.to_flag), 1);
    check("coll_tick", 0, 32'(if0.to_tick), 1);
    check("coll_evt_w2", 2, 32'(if2.to_evt_cnt), 1);
    step(ACT);
    clr = 1'b0;
    check("clr_evt",  0, 32'(if0.to_evt_cnt), 0);
    check("clr_flag", 0, 32'(if0.to_flag), 0);
    for (int i = 0; i < 18; i++) step(ACT);
    check("sat_evt_w2", 2, 32'(if2.to_evt_cnt), 3);
    check("nosat_evt",  0, 32'(if0.to_evt_cnt), 6);

    // Lowering the limit below the running count fires on the next edge.
    do_reset();
    lim = 16'd100;
    step(ACT);
    for (int i = 0; i < 50; i++) step(ACT);
    check("pre_low_cnt", 0, 32'(if0.to_cnt), 50);
    lim = 16'd20;
    step(ACT);
    check("low_tick0", 0, 32'(if0.to_tick), 1);
    check("low_cnt0",  0, 32'(if0.to_cnt), 0);
    check("low_tick1", 1, 32'(if1.to_tick), 1);
    check("low_cnt1",  1, 32'(if1.to_cnt), 50);

    // Reset in the middle of a long dwell with the flag already set.
    do_reset();
    lim = 16'd5;
    step(ACT);
    for (int i = 0; i < 6; i++) step(ACT);
    lim = '0;
    for (int i = 0; i < 300; i++) step(ACT);
    check("mid_cnt",  0, 32'(if0.to_cnt), 300);
    check("mid_flag", 0, 32'(if0.to_flag), 1);
    rst = 1'b1;
    step(ACT);
    check("mrst_cnt",   0, 32'(if0.to_cnt), 0);
    check("mrst_flag",  0, 32'(if0.to_flag), 0);
    check("mrst_evt",   0, 32'(if0.to_evt_cnt), 0);
    check("mrst_state", 0, 32'(if0.to_state), int'(IDLE));
    step(ACT);
    rst = 1'b0;

    // Table of hand-derived vectors.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      st  = tbl[i].s;
      pst = tbl[i].p;
      lim = 16'(tbl[i].lim);
      clr = tbl[i].clr;
      cyc();
      check("tbl_cnt",   1, 32'(if1.to_cnt),     tbl[i].cnt);
      check("tbl_tick",  1, 32'(if1.to_tick),    tbl[i].tick);
      check("tbl_flag",  1, 32'(if1.to_flag),    tbl[i].flag);
      check("tbl_evt",   1, 32'(if1.to_evt_cnt), tbl[i].evt);
      check("tbl_state", 1, 32'(if1.to_state),   int'(tbl[i].ts));
    end
    clr = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      mpmc11_state_t ns;
      if ($urandom_range(0, 9) == 0) ns = mpmc11_state_t'(3'($urandom_range(0, 3)));
      else                           ns = st;
      if (i % 200 == 0) lim = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 15));
      pst = ($urandom_range(0, 49) == 0) ? mpmc11_state_t'(3'($urandom_range(0, 3))) : st;
      st  = ns;
      clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst = 1'b0;
    clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
